nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands one nibble per clock through a single 4-bit CLA slice.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum of products of cin, p and g.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic [IW-1:0]   idx_reg;
    logic            carry_reg;
    logic            load;
    logic            step;
    logic            last;
    logic [3:0]      cla_a;
    logic [3:0]      cla_b;
    logic [3:0]      cla_s;
    logic            cla_cout;

    assign last  = (idx_reg == IW'(NIBBLES - 1));
    assign cla_a = a_reg[{idx_reg, 2'b00} +: 4];
    assign cla_b = b_reg[{idx_reg, 2'b00} +: 4];

    cla u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_reg),
        .s    (cla_s),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= b;
            idx_reg   <= '0;
            carry_reg <= cin;
        end else if (step) begin
            sum_reg[{idx_reg, 2'b00} +: 4] <= cla_s;
            carry_reg                      <= cla_cout;
            // idx is compared before incrementing, so it never wraps.
            if (!last) begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = carry_reg;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // On the MSB nibble, s[3]^a^b recovers the carry into bit W-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (step && last) begin
            ovf_reg <= cla_s[3] ^ a_reg[W-1] ^ b_reg[W-1] ^ cla_cout;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule
